// File: rtl/plic_target_claim.sv
// plic_target_claim: registers the comparator-tree winner, gates it against the threshold
// and runs the per-target claim/complete handshake towards the target and the gateways.
module plic_target_claim #(
    parameter int ID_BITWIDTH       = 4,
    parameter int PRIORITY_BITWIDTH = 3
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [PRIORITY_BITWIDTH-1:0] max_priority_i,
    input  logic [ID_BITWIDTH-1:0]       max_id_i,
    input  logic [PRIORITY_BITWIDTH-1:0] threshold_i,
    output logic                         irq_o,
    input  logic                         claim_req_i,
    output logic                         claim_valid_o,
    output logic [ID_BITWIDTH-1:0]       claim_id_o,
    input  logic                         complete_req_i,
    input  logic [ID_BITWIDTH-1:0]       complete_id_i,
    output logic                         claimed_o,
    output logic                         completed_o,
    output logic [ID_BITWIDTH-1:0]       gw_id_o,
    output logic                         cpl_err_o
);
    typedef enum logic {IDLE, CLAIMED} state_e;
    state_e                         r_state, w_state_n;
    logic [PRIORITY_BITWIDTH-1:0]   r_prio, r_thr;
    logic [ID_BITWIDTH-1:0]         r_id, r_held_id, w_held_id_n;
    logic [ID_BITWIDTH-1:0]         r_claim_id, w_claim_id_n, r_gw_id, w_gw_id_n;
    logic                           r_claim_valid, r_claimed, r_completed, r_cpl_err;
    logic                           w_eligible, w_cpl_ok, w_claim_ok;
    assign w_eligible = (r_prio > r_thr) && (r_id != '0);
    assign irq_o      = w_eligible && (r_state == IDLE);
    // A completion is judged first; a claim sharing its cycle is always answered empty.
    always_comb begin
        w_cpl_ok     = complete_req_i && (r_state == CLAIMED) && (complete_id_i == r_held_id);
        w_claim_ok   = claim_req_i && !complete_req_i && (r_state == IDLE) && w_eligible;
        w_state_n    = w_cpl_ok ? IDLE : (w_claim_ok ? CLAIMED : r_state);
        w_held_id_n  = w_claim_ok ? r_id : r_held_id;
        w_claim_id_n = claim_req_i ? (w_claim_ok ? r_id : '0) : r_claim_id;
        w_gw_id_n    = w_claim_ok ? r_id : (w_cpl_ok ? r_held_id : '0);
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= IDLE;
            r_prio        <= '0;
            r_id          <= '0;
            r_thr         <= '0;
            r_held_id     <= '0;
            r_claim_valid <= 1'b0;
            r_claim_id    <= '0;
            r_claimed     <= 1'b0;
            r_completed   <= 1'b0;
            r_gw_id       <= '0;
            r_cpl_err     <= 1'b0;
        end else begin
            r_state       <= w_state_n;
            r_prio        <= max_priority_i;
            r_id          <= max_id_i;
            r_thr         <= threshold_i;
            r_held_id     <= w_held_id_n;
            r_claim_valid <= claim_req_i;
            r_claim_id    <= w_claim_id_n;
            r_claimed     <= w_claim_ok;
            r_completed   <= w_cpl_ok;
            r_gw_id       <= w_gw_id_n;
            r_cpl_err     <= complete_req_i && !w_cpl_ok;
        end
    end
    assign claim_valid_o = r_claim_valid;
    assign claim_id_o    = r_claim_id;
    assign claimed_o     = r_claimed;
    assign completed_o   = r_completed;
    assign gw_id_o       = r_gw_id;
    assign cpl_err_o     = r_cpl_err;
endmodule

// File: tb/tb_plic_target_claim.sv
// tb_plic_target_claim: directed claim/complete scenarios checked against a behavioural
// model every cycle, plus hand-computed literal checks that pin the model.
module tb_plic_target_claim;
    logic       clk_i, rst_ni;
    logic [2:0] max_priority_i, threshold_i;
    logic [3:0] max_id_i, complete_id_i;
    logic       claim_req_i, complete_req_i;
    logic       irq_o, claim_valid_o, claimed_o, completed_o, cpl_err_o;
    logic [3:0] claim_id_o, gw_id_o;
    int         n_checks = 0;
    int         n_errors = 0;
    // model: registered tree inputs, the ID in service (0 = none) and expected pulses
    int         m_pq = 0, m_iq = 0, m_tq = 0, m_svc = 0;
    int         e_cv = 0, e_cid = 0, e_claimed = 0, e_completed = 0, e_gw = 0, e_err = 0;

    plic_target_claim #(.ID_BITWIDTH(4), .PRIORITY_BITWIDTH(3)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .max_priority_i(max_priority_i), .max_id_i(max_id_i), .threshold_i(threshold_i),
        .irq_o(irq_o),
        .claim_req_i(claim_req_i), .claim_valid_o(claim_valid_o), .claim_id_o(claim_id_o),
        .complete_req_i(complete_req_i), .complete_id_i(complete_id_i),
        .claimed_o(claimed_o), .completed_o(completed_o), .gw_id_o(gw_id_o),
        .cpl_err_o(cpl_err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk_i or negedge rst_ni) begin
        bit el, legal, grant;
        if (!rst_ni) begin
            m_pq <= 0; m_iq <= 0; m_tq <= 0; m_svc <= 0;
            e_cv <= 0; e_cid <= 0; e_claimed <= 0; e_completed <= 0; e_gw <= 0; e_err <= 0;
        end else begin
            el    = (m_pq > m_tq) && (m_iq != 0);
            legal = complete_req_i && (m_svc != 0) && (int'(complete_id_i) == m_svc);
            grant = claim_req_i && !complete_req_i && (m_svc == 0) && el;
            e_cv        <= int'(claim_req_i);
            if (claim_req_i) e_cid <= grant ? m_iq : 0;
            e_claimed   <= int'(grant);
            e_completed <= int'(legal);
            e_gw        <= grant ? m_iq : (legal ? m_svc : 0);
            e_err       <= int'(complete_req_i && !legal);
            if (legal) m_svc <= 0;
            else if (grant) m_svc <= m_iq;
            m_pq <= int'(max_priority_i);
            m_iq <= int'(max_id_i);
            m_tq <= int'(threshold_i);
        end
    end

    always @(negedge clk_i) begin
        chk("irq", irq_o, int'((m_pq > m_tq) && (m_iq != 0) && (m_svc == 0)));
        chk("claim_valid", claim_valid_o, e_cv);
        chk("claim_id", claim_id_o, e_cid);
        chk("claimed", claimed_o, e_claimed);
        chk("completed", completed_o, e_completed);
        chk("gw_id", gw_id_o, e_gw);
        chk("cpl_err", cpl_err_o, e_err);
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic set_tree(input int p, input int id, input int t);
        max_priority_i = 3'(p); max_id_i = 4'(id); threshold_i = 3'(t);
    endtask

    task automatic claim();
        claim_req_i = 1'b1; tick(); claim_req_i = 1'b0;
    endtask

    task automatic complete(input int id);
        complete_req_i = 1'b1; complete_id_i = 4'(id); tick(); complete_req_i = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0;
        claim_req_i = 1'b0; complete_req_i = 1'b0; complete_id_i = '0;
        set_tree(5, 3, 2);
        tick(2);
        chk("rst_irq_lit", irq_o, 0);
        chk("rst_outs_lit", {claim_valid_o, claim_id_o, claimed_o, completed_o, gw_id_o, cpl_err_o}, 0);
        rst_ni = 1'b1;
        tick();
        chk("thr_gate_on_lit", irq_o, 1);
        threshold_i = 3'd5;
        tick();
        chk("thr_gate_off_lit", irq_o, 0);

        set_tree(6, 9, 1);
        tick();
        chk("irq_pre_claim_lit", irq_o, 1);
        claim();
        chk("claim_id_lit", claim_id_o, 9);
        chk("claimed_lit", claimed_o, 1);
        chk("claim_gw_lit", gw_id_o, 9);
        chk("claim_irq_lit", irq_o, 0);

        complete(4);
        chk("bad_cpl_err_lit", cpl_err_o, 1);
        chk("bad_cpl_irq_lit", irq_o, 0);
        claim();
        chk("dup_claim_id_lit", claim_id_o, 0);
        chk("dup_claimed_lit", claimed_o, 0);
        threshold_i = 3'd0;
        tick();
        chk("claimed_irq_masked_lit", irq_o, 0);
        threshold_i = 3'd1;
        complete(9);
        chk("cpl_lit", completed_o, 1);
        chk("cpl_gw_lit", gw_id_o, 9);
        tick();
        chk("irq_back_lit", irq_o, 1);

        complete(9);
        chk("idle_cpl_err_lit", cpl_err_o, 1);

        set_tree(6, 0, 1);
        tick();
        claim();
        chk("empty_id0_valid_lit", claim_valid_o, 1);
        chk("empty_id0_lit", claim_id_o, 0);
        chk("empty_id0_claimed_lit", claimed_o, 0);
        set_tree(3, 5, 3);
        tick();
        claim();
        chk("empty_prio_eq_thr_lit", claim_id_o, 0);
        set_tree(0, 5, 0);
        tick();
        claim();
        chk("empty_prio0_lit", claim_id_o, 0);

        set_tree(6, 9, 1);
        tick();
        claim();
        claim_req_i = 1'b1; complete_req_i = 1'b1; complete_id_i = 4'd9;
        tick();
        claim_req_i = 1'b0; complete_req_i = 1'b0;
        chk("simul_completed_lit", completed_o, 1);
        chk("simul_valid_lit", claim_valid_o, 1);
        chk("simul_claim_id_lit", claim_id_o, 0);
        chk("simul_claimed_lit", claimed_o, 0);
        claim();
        chk("post_simul_claim_lit", claim_id_o, 9);

        #2 rst_ni = 1'b0;
        #1;
        chk("async_rst_claimed_lit", claimed_o, 0);
        chk("async_rst_id_lit", claim_id_o, 0);
        chk("async_rst_gw_lit", gw_id_o, 0);
        chk("async_rst_completed_lit", completed_o, 0);
        tick();
        rst_ni = 1'b1;
        tick();
        claim();
        chk("post_rst_claim_lit", claim_id_o, 9);

        for (int i = 0; i < 40; i++) begin
            set_tree($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3));
            claim_req_i    = 1'($urandom_range(0, 1));
            complete_req_i = 1'($urandom_range(0, 1));
            complete_id_i  = 4'($urandom_range(0, 3));
            tick();
        end
        claim_req_i = 1'b0; complete_req_i = 1'b0;
        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
